// File: rtl/status_context_stack.sv
// rtl/status_context_stack.sv - status register with a nested-interrupt context stack and CEX counter
module status_context_stack #(
    parameter int WORD  = 16,
    parameter int FLAGS = 4,
    parameter int PLVLS = 8,
    parameter int DEPTH = 4,
    parameter int CEXW  = 3,
    parameter int PRIVW = $clog2(PLVLS),
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                wrEn_i,
    input  logic [WORD/8-1:0]   wrMode_i,
    input  logic [WORD-1:0]     data_i,
    input  logic                flagsWr_i,
    input  logic [FLAGS-1:0]    flagsEn_i,
    input  logic [FLAGS-1:0]    flags_i,
    input  logic                clrSlp_i,
    input  logic                setPriv_i,
    input  logic [PRIVW-1:0]    priv_i,
    input  logic                cexLoad_i,
    input  logic [CEXW-1:0]     cexCnt_i,
    input  logic                instrDone_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic                errClr_i,
    output logic [FLAGS-1:0]    flags_o,
    output logic                slp_o,
    output logic                ie_o,
    output logic [PRIVW-1:0]    currPriv_o,
    output logic [PRIVW-1:0]    prevPriv_o,
    output logic [CEXW-1:0]     cex_o,
    output logic                cexActive_o,
    output logic [WORD-1:0]     data_o,
    output logic [DW-1:0]       depth_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                ovf_o,
    output logic                unf_o,
    output logic                colErr_o
);
    localparam int CUR_LO = WORD - PRIVW;
    localparam int PRV_LO = WORD - 2 * PRIVW;
    localparam int CEX_LO = FLAGS + 2;
    localparam int IE_B   = FLAGS + 1;
    localparam int SLP_B  = FLAGS;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAGS-1:0] flags_q, flags_d;
    logic             slp_q, slp_d, ie_q, ie_d;
    logic [PRIVW-1:0] curr_q, curr_d, prev_q, prev_d;
    logic [CEXW-1:0]  cex_q, cex_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, col_q, col_d;
    logic [WORD-1:0]  stack_q [DEPTH];
    logic [WORD-1:0]  live_word, top_word;
    logic [AW-1:0]    push_idx, pop_idx;
    logic             stack_we;
    logic             full, empty;

    assign full     = (depth_q == DW'(DEPTH));
    assign empty    = (depth_q == '0);
    assign push_idx = AW'(depth_q);
    assign pop_idx  = AW'(depth_q - DW'(1));
    assign top_word = stack_q[pop_idx];

    // Unused reserved bits read as zero so saved words compare cleanly.
    always_comb begin
        live_word                         = '0;
        live_word[WORD-1:CUR_LO]          = curr_q;
        live_word[CUR_LO-1:PRV_LO]        = prev_q;
        live_word[CEX_LO+CEXW-1:CEX_LO]   = cex_q;
        live_word[IE_B]                   = ie_q;
        live_word[SLP_B]                  = slp_q;
        live_word[FLAGS-1:0]              = flags_q;
    end

    always_comb begin
        flags_d  = flags_q;
        slp_d    = slp_q;
        ie_d     = ie_q;
        curr_d   = curr_q;
        prev_d   = prev_q;
        cex_d    = cex_q;
        depth_d  = depth_q;
        ovf_d    = ovf_q & ~errClr_i;
        unf_d    = unf_q & ~errClr_i;
        col_d    = col_q & ~errClr_i;
        stack_we = 1'b0;
        if (push_i && pop_i) begin
            col_d = 1'b1;
        end else if (push_i) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                stack_we = 1'b1;
                depth_d  = depth_q + DW'(1);
                curr_d   = priv_i;
                prev_d   = curr_q;
                ie_d     = 1'b0;
                slp_d    = 1'b0;
                cex_d    = '0;
            end
        end else if (pop_i) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth_q - DW'(1);
                curr_d  = top_word[WORD-1:CUR_LO];
                prev_d  = top_word[CUR_LO-1:PRV_LO];
                cex_d   = top_word[CEX_LO+CEXW-1:CEX_LO];
                ie_d    = top_word[IE_B];
                slp_d   = top_word[SLP_B];
                flags_d = top_word[FLAGS-1:0];
            end
        end else begin
            if (wrEn_i) begin
                if (wrMode_i[0]) begin
                    flags_d = data_i[FLAGS-1:0];
                    slp_d   = data_i[SLP_B];
                    ie_d    = data_i[IE_B];
                end
                if (wrMode_i[WORD/8-1]) begin
                    curr_d = data_i[WORD-1:CUR_LO];
                    prev_d = data_i[CUR_LO-1:PRV_LO];
                end
            end else begin
                if (clrSlp_i)
                    slp_d = 1'b0;
                if (flagsWr_i)
                    flags_d = (flags_q & ~flagsEn_i) | (flags_i & flagsEn_i);
                if (setPriv_i) begin
                    curr_d = priv_i;
                    prev_d = curr_q;
                end
            end
            if (cexLoad_i)
                cex_d = cexCnt_i;
            else if (instrDone_i && cex_q != '0)
                cex_d = cex_q - CEXW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            flags_q <= '0;
            slp_q   <= 1'b0;
            ie_q    <= 1'b0;
            curr_q  <= '0;
            prev_q  <= '0;
            cex_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            col_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                stack_q[i] <= '0;
        end else begin
            flags_q <= flags_d;
            slp_q   <= slp_d;
            ie_q    <= ie_d;
            curr_q  <= curr_d;
            prev_q  <= prev_d;
            cex_q   <= cex_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            col_q   <= col_d;
            if (stack_we)
                stack_q[push_idx] <= live_word;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{data_i, top_word};

    assign flags_o     = flags_q;
    assign slp_o       = slp_q;
    assign ie_o        = ie_q;
    assign currPriv_o  = curr_q;
    assign prevPriv_o  = prev_q;
    assign cex_o       = cex_q;
    assign cexActive_o = (cex_q != '0);
    assign data_o      = live_word;
    assign depth_o     = depth_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign ovf_o       = ovf_q;
    assign unf_o       = unf_q;
    assign colErr_o    = col_q;
endmodule

// File: tb/tb_status_context_stack.sv
// tb/tb_status_context_stack.sv - directed bench with a queue-based status/stack model
module tb_status_context_stack;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        wrEn = 0;
    logic [1:0]  wrMode = 0;
    logic [15:0] wdata = 0;
    logic        flagsWr = 0;
    logic [3:0]  flagsEn = 0, flagsIn = 0;
    logic        clrSlp = 0, setPriv = 0;
    logic [2:0]  priv = 0;
    logic        cexLoad = 0;
    logic [2:0]  cexCnt = 0;
    logic        instrDone = 0, push = 0, pop = 0, errClr = 0;

    logic [3:0]  flags_o;
    logic        slp_o, ie_o, cexActive_o, full_o, empty_o, ovf_o, unf_o, colErr_o;
    logic [2:0]  currPriv_o, prevPriv_o, cex_o, depth_o;
    logic [15:0] data_o;

    status_context_stack dut (
        .clk_i(clk), .arst_i(arst), .wrEn_i(wrEn), .wrMode_i(wrMode), .data_i(wdata),
        .flagsWr_i(flagsWr), .flagsEn_i(flagsEn), .flags_i(flagsIn), .clrSlp_i(clrSlp),
        .setPriv_i(setPriv), .priv_i(priv), .cexLoad_i(cexLoad), .cexCnt_i(cexCnt),
        .instrDone_i(instrDone), .push_i(push), .pop_i(pop), .errClr_i(errClr),
        .flags_o(flags_o), .slp_o(slp_o), .ie_o(ie_o), .currPriv_o(currPriv_o),
        .prevPriv_o(prevPriv_o), .cex_o(cex_o), .cexActive_o(cexActive_o), .data_o(data_o),
        .depth_o(depth_o), .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o),
        .unf_o(unf_o), .colErr_o(colErr_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;

    int m_cur, m_prv, m_cex, m_ie, m_slp, m_flags;
    bit m_ovf, m_unf, m_col;
    logic [15:0] m_stack[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack();
        int w;
        w = m_cur * 8192 + m_prv * 1024 + m_cex * 64 + m_ie * 32 + m_slp * 16 + m_flags;
        return w[15:0];
    endfunction

    task automatic model_reset();
        m_cur = 0; m_prv = 0; m_cex = 0; m_ie = 0; m_slp = 0; m_flags = 0;
        m_ovf = 0; m_unf = 0; m_col = 0;
        m_stack.delete();
    endtask

    task automatic model_step();
        logic [15:0] w;
        if (errClr) begin m_ovf = 0; m_unf = 0; m_col = 0; end
        if (push && pop) begin
            m_col = 1;
        end else if (push) begin
            if (m_stack.size() == DEPTH) m_ovf = 1;
            else begin
                m_stack.push_back(pack());
                m_prv = m_cur; m_cur = priv; m_ie = 0; m_slp = 0; m_cex = 0;
            end
        end else if (pop) begin
            if (m_stack.size() == 0) m_unf = 1;
            else begin
                w = m_stack.pop_back();
                m_cur = w / 8192; m_prv = (w / 1024) % 8; m_cex = (w / 64) % 8;
                m_ie = (w / 32) % 2; m_slp = (w / 16) % 2; m_flags = w % 16;
            end
        end else begin
            if (wrEn) begin
                if (wrMode[0]) begin
                    m_flags = wdata % 16; m_slp = (wdata / 16) % 2; m_ie = (wdata / 32) % 2;
                end
                if (wrMode[1]) begin
                    m_cur = wdata / 8192; m_prv = (wdata / 1024) % 8;
                end
            end else begin
                if (clrSlp) m_slp = 0;
                if (flagsWr)
                    for (int b = 0; b < 4; b++)
                        if (flagsEn[b]) m_flags = flagsIn[b] ? (m_flags | (1 << b)) : (m_flags & ~(1 << b));
                if (setPriv) begin m_prv = m_cur; m_cur = priv; end
            end
            if (cexLoad) m_cex = cexCnt;
            else if (instrDone && m_cex > 0) m_cex = m_cex - 1;
        end
    endtask

    task automatic clr_in();
        wrEn = 0; wrMode = 0; wdata = 0; flagsWr = 0; flagsEn = 0; flagsIn = 0;
        clrSlp = 0; setPriv = 0; priv = 0; cexLoad = 0; cexCnt = 0;
        instrDone = 0; push = 0; pop = 0; errClr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        clr_in();
    endtask

    always @(negedge clk) begin
        if (chk_en && !arst) begin
            chk("data_o", data_o, pack());
            chk("depth_o", depth_o, m_stack.size());
            chk("status_bits", {full_o, empty_o, ovf_o, unf_o, colErr_o, cexActive_o},
                {m_stack.size() == DEPTH, m_stack.size() == 0, m_ovf, m_unf, m_col, m_cex != 0});
            chk("fields", {flags_o, slp_o, ie_o, currPriv_o, prevPriv_o, cex_o},
                {m_flags[3:0], m_slp[0], m_ie[0], m_cur[2:0], m_prv[2:0], m_cex[2:0]});
        end
    end

    logic [15:0] saved;

    initial begin
        model_reset();
        #12 arst = 0;
        chk("rst_data", data_o, 16'h0000);
        chk("rst_depth", depth_o, 3'd0);
        chk("rst_flags", {empty_o, full_o, ovf_o, unf_o, colErr_o}, 5'b10000);
        chk_en = 1;

        wrEn = 1; wrMode = 2'b11; wdata = 16'h4035; cyc();
        chk("wr_word", data_o, 16'h4035);
        push = 1; priv = 3'd7; cyc();
        chk("push_word", data_o, 16'hE805);
        chk("push_depth", depth_o, 3'd1);
        pop = 1; cyc();
        chk("pop_word", data_o, 16'h4035);
        chk("pop_empty", empty_o, 1'b1);
        pop = 1; cyc();
        chk("unf", unf_o, 1'b1);
        chk("unf_word", data_o, 16'h4035);

        errClr = 1; cyc();
        flagsWr = 1; flagsEn = 4'hF; flagsIn = 4'hA; cyc();
        cexLoad = 1; cexCnt = 3'd5; cyc();
        push = 1; priv = 3'd1; cyc();
        setPriv = 1; priv = 3'd4; clrSlp = 1; cyc();
        push = 1; priv = 3'd3; cyc();
        wrEn = 1; wrMode = 2'b01; wdata = 16'h003C; clrSlp = 1; cyc();
        push = 1; priv = 3'd5; cyc();
        push = 1; priv = 3'd6; cyc();
        chk("full", full_o, 1'b1);
        push = 1; priv = 3'd2; cyc();
        chk("ovf", ovf_o, 1'b1);
        chk("ovf_depth", depth_o, 3'd4);
        for (int i = 0; i < 4; i++) begin pop = 1; cyc(); end
        chk("lifo_bottom", data_o, 16'h417A);

        errClr = 1; cexLoad = 1; cexCnt = 3'd3; cyc();
        chk("cex_load", cex_o, 3'd3);
        instrDone = 1; cyc(); chk("cex_dec1", cex_o, 3'd2);
        instrDone = 1; cyc(); chk("cex_dec2", cex_o, 3'd1);
        instrDone = 1; cyc(); chk("cex_dec3", {cex_o, cexActive_o}, 4'b0000);
        instrDone = 1; cyc(); chk("cex_sat", cex_o, 3'd0);
        cexLoad = 1; cexCnt = 3'd6; instrDone = 1; cyc();
        chk("cex_load_wins", cex_o, 3'd6);

        wrEn = 1; wrMode = 2'b10; wdata = 16'hA000; setPriv = 1; priv = 3'd1; flagsWr = 1; flagsEn = 4'hF; cyc();
        chk("wr_hi_priv", {currPriv_o, prevPriv_o}, 6'b101000);
        flagsWr = 1; flagsEn = 4'b0110; flagsIn = 4'b0100; setPriv = 1; priv = 3'd3; instrDone = 1; cyc();

        saved = data_o;
        push = 1; pop = 1; flagsWr = 1; flagsEn = 4'hF; flagsIn = 4'h0; priv = 3'd7; cyc();
        chk("col_err", colErr_o, 1'b1);
        chk("col_nochange", data_o, saved);
        errClr = 1; cyc();
        chk("col_clr", colErr_o, 1'b0);

        push = 1; priv = 3'd2; cyc();
        push = 1; priv = 3'd6; cyc();
        chk("depth2", depth_o, 3'd2);
        #2 arst = 1;
        model_reset();
        #1;
        chk("arst_data", data_o, 16'h0000);
        chk("arst_state", {depth_o, empty_o, full_o, ovf_o, unf_o, colErr_o, cex_o}, {3'd0, 1'b1, 4'b0000, 3'd0});
        #2 arst = 0;
        pop = 1; cyc();
        chk("post_rst_unf", unf_o, 1'b1);
        push = 1; priv = 3'd4; cyc();
        pop = 1; cyc();
        chk("post_rst_stack", data_o, 16'h0000);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/status_context_stack.md
# status_context_stack

Status register with a parametrised hardware context stack for nested interrupts and a conditional-execution counter held in the reserved field. Interrupt entry pushes the live status word and enters the handler's privilege with IE, SLP and CEX cleared. Interrupt return pops the saved word back in one cycle. The block sits in the control unit next to the register file and is driven by the multi-cycle controller's interrupt-entry and return states.

## Interface
- WORD, 16, status word width; multiple of 8
- FLAGS, 4, number of flag bits (C, Z, N, V)
- PLVLS, 8, privilege levels; PRIVW = $clog2(PLVLS)
- DEPTH, 4, context stack entries; at least 1
- CEXW, 3, CEX counter width; at most WORD-FLAGS-2*PRIVW-2

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- arst_i  in  1  reset; asynchronous and active-high
- wrEn_i  in  1  software write of the status word
- wrMode_i  in  WORD/8  byte enables for wrEn_i
- data_i  in  WORD  write data
- flagsWr_i  in  1  per-bit flag update strobe
- flagsEn_i, flags_i  in  FLAGS  flag bit enables and values
- clrSlp_i  in  1  clear SLP
- setPriv_i  in  1  privilege change
- priv_i  in  PRIVW  new privilege for setPriv_i or push_i
- cexLoad_i  in  1  load the CEX counter
- cexCnt_i  in  CEXW  CEX load value
- instrDone_i  in  1  instruction retired; decrements CEX
- push_i  in  1  interrupt entry, single-cycle pulse
- pop_i  in  1  interrupt return, single-cycle pulse
- errClr_i  in  1  clear the sticky error bits
- flags_o  out  FLAGS; slp_o, ie_o  out  1; currPriv_o, prevPriv_o  out  PRIVW; cex_o  out  CEXW: live fields
- cexActive_o  out  1  high when cex_o != 0
- data_o  out  WORD  packed status word, combinational from the live fields
- depth_o  out  $clog2(DEPTH+1)  number of occupied stack entries
- full_o, empty_o  out  1  depth_o==DEPTH and depth_o==0
- ovf_o, unf_o, colErr_o  out  1  sticky errors: push on full, pop on empty, push and pop asserted together

## Operation
- Word layout, MSB to LSB:
  - Curr privilege: [WORD-1 : WORD-PRIVW]
  - Prev privilege: the next PRIVW bits below Curr
  - Reserved field: the bits between Prev and IE; CEX occupies its low CEXW bits, starting at FLAGS+2, and the unused reserved bits read 0
  - IE: bit FLAGS+1
  - SLP: bit FLAGS
  - Flags: [FLAGS-1:0]
- Update priority within a cycle: arst_i, then push/pop, then wrEn_i, then the individual strobes. While push_i or pop_i is asserted, all other write strobes are ignored.
- Push (push_i=1, pop_i=0, not full):
  - stack[depth] <= data_o and depth is incremented.
  - Live register: currPriv <= priv_i, prevPriv <= old currPriv, IE <= 0, SLP <= 0, CEX <= 0. Flags are unchanged.
- Pop (pop_i=1, push_i=0, not empty):
  - depth is decremented.
  - Every field of the live register is restored from stack[depth-1], including CEX.
- Push while full: no state change except ovf_o <= 1. Pop while empty: no state change except unf_o <= 1.
- push_i and pop_i asserted together: neither operation acts and colErr_o <= 1. The other strobes are ignored that cycle.
- wrEn_i:
  - wrMode_i[0] writes flags, SLP and IE.
  - wrMode_i[WORD/8-1] writes Curr and Prev.
  - CEX is never written through wrEn_i.
  - While wrEn_i is high the individual strobes are ignored.
- Individual strobes may combine in one cycle: clrSlp_i, the masked flag write (flagsWr_i with flagsEn_i), and setPriv_i (currPriv <= priv_i, prevPriv <= old currPriv).
- CEX counter:
  - cexLoad_i loads cexCnt_i. If cexLoad_i and instrDone_i coincide, the load wins.
  - Otherwise instrDone_i decrements CEX, saturating at 0.
  - The CEX load and decrement operate alongside wrEn_i and the other individual strobes, but not during a push or pop cycle.
- errClr_i clears all sticky error bits. If an error occurs in the same cycle as errClr_i, the new error wins.

## Timing
- Reset: all live fields are 0, every stack entry is 0, depth_o=0, empty_o=1, full_o=0, and all error outputs are 0.
- Every state change is visible on the outputs in the cycle after the rising edge that sampled the strobe.
- Push and pop each take one cycle, so back-to-back pushes or pops are allowed on consecutive cycles.
- data_o, full_o, empty_o and cexActive_o are combinational from registered state; there is no input-to-output combinational path.
- When arst_i asserts during a nested sequence, all state returns to the reset values immediately, regardless of the clock.

## Test plan
- Reset, then wrEn_i with wrMode_i=2'b11 and data_i=16'h4035 (Curr=2, IE=1, SLP=1, flags=4'h5) -> data_o=16'h4035. Then push_i with priv_i=7 -> data_o=16'hE805, depth_o=1, stack[0]=16'h4035.
- From the previous state, pop_i -> data_o=16'h4035 and empty_o=1. A further pop_i -> unf_o=1 and data_o unchanged.
- Four pushes fill the stack: full_o=1. A fifth push_i -> ovf_o=1 and depth_o stays 4. Four pops then restore the pushed words in LIFO order.
- cexLoad_i with cexCnt_i=3, then three instrDone_i pulses -> cex_o reads 3, 2, 1, 0 and cexActive_o drops after the third pulse. A fourth pulse holds 0.
- push_i and pop_i asserted together with flagsWr_i -> colErr_o=1 and no field changes. errClr_i on the next cycle -> colErr_o=0.
- arst_i pulsed mid-cycle at depth 2 -> all outputs return to their reset values before the next clock edge.
